ukf_sigma_seq: RTL and testbench
================================

Name: ukf_sigma_seq

Overview:
- Upstream stage of the UKF weighted-mean accumulator.
- Takes the state mean vector and the columns of the scaled covariance square root (gamma·sqrt(P), read from a column RAM) and streams the 2N+1 sigma points with their weights.
- Each point is a parallel N_STATE-element Q(INT_BITS).(FRAC_BITS) vector paired with its weight, under a valid/ready handshake.
- The consumer asserts its accumulate enable on each handshake.

Parameters:
- DATA_W, 32, element width, signed two's-complement fixed point.
- INT_BITS, 8, integer bits including sign.
- FRAC_BITS, 24, fractional bits; INT_BITS+FRAC_BITS == DATA_W.
- N_STATE, 6, state dimension N.
- COL_AW, 3, column RAM address width, >= clog2(N_STATE).
- IDX_W, 4, sigma index width, >= clog2(2*N_STATE+1).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- mean  in  N_STATE*DATA_W  mean vector, element j at bits [j*DATA_W +: DATA_W]; sampled on start.
- w0  in  DATA_W  weight of point 0; sampled on start.
- wi  in  DATA_W  weight of points 1..2N; sampled on start.
- col_rd_en  out  1  column RAM read strobe.
- col_addr  out  COL_AW  column index.
- col_data  in  N_STATE*DATA_W  column read data; valid exactly 1 cycle after col_rd_en.
- sp_valid  out  1  sigma point valid.
- sp_ready  in  1  consumer ready.
- sp_data  out  N_STATE*DATA_W  sigma point.
- sp_w  out  DATA_W  weight of the current point.
- sp_idx  out  IDX_W  sigma index 0..2N.
- sp_last  out  1  current point is index 2N.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sequence end.
- sat_flag  out  1  sticky saturation indicator.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal mean/column/weight registers 0.
- Reset mid-sequence aborts immediately with no done pulse.
- States: IDLE, EMIT_MEAN, FETCH, WAIT, EMIT_POS, EMIT_NEG, FINISH.
- IDLE:
  - start=1 latches mean, w0 and wi; clears sat_flag; loads sp_data=mean, sp_w=w0, sp_idx=0.
  - Next state EMIT_MEAN; sp_valid is high from the following cycle.
  - start in any other state is ignored.
- EMIT_MEAN: sp_valid=1. On handshake (sp_valid&&sp_ready): column counter c=0, go to FETCH.
- FETCH: col_rd_en=1, col_addr=c for exactly one cycle; go to WAIT.
- WAIT:
  - Capture col_data into the column register.
  - Register sp_data[j]=sat(mean[j]+col[j]), sp_w=wi, sp_idx=2c+1.
  - Go to EMIT_POS.
- EMIT_POS: sp_valid=1. On handshake: register sp_data[j]=sat(mean[j]-col[j]), sp_idx=2c+2; go to EMIT_NEG.
- EMIT_NEG: sp_valid=1; sp_last=1 when c==N_STATE-1. On handshake:
  - If c==N_STATE-1: go to FINISH.
  - Otherwise: c=c+1, go to FETCH.
- FINISH: done=1 for one cycle, sp_valid=0; go to IDLE.
- Handshake rules:
  - While sp_valid=1 and sp_ready=0, sp_data, sp_w, sp_idx and sp_last are held stable.
  - sp_valid never deasserts without a handshake.
  - sp_ready is ignored while sp_valid=0.
- Emission order: mean, +col0, -col0, +col1, -col1, …; 2N+1 points per sequence (13 at default).
- Minimum sequence length with sp_ready tied high: 1+4N+1 cycles after start.
- Arithmetic:
  - Element-wise signed DATA_W add/subtract, computed at DATA_W+1 bits.
  - Result is saturated or wrapped per the optional feature.
  - Weights are passed through unchanged; no multiplication in this block.
- Only one column read is issued per column; the captured column is reused for the negative point.

Optional Feature:
- Macro UKF_SIGMA_SAT_EN.
- Defined:
  - Any element overflow clamps to 0x7FFFFFFF (positive) or 0x80000000 (negative) at DATA_W=32.
  - sat_flag is set on the cycle the clamped point is registered and stays high until the next accepted start or reset.
- Undefined:
  - Results wrap modulo 2^DATA_W.
  - sat_flag is tied 0.

Test Plan:
- Basic sequence:
  - Stimulus: mean all 0x01000000 (1.0), every column all 0x00800000 (0.5), w0=0x00555555, wi=0x00155555, sp_ready=1.
  - Required: 13 points; idx0=0x01000000 with w0; odd idx=0x01800000; even idx>0=0x00800000 with wi; sp_last only at idx12; done one cycle after the idx12 handshake.
- Backpressure:
  - Stimulus: drop sp_ready for 3 cycles while +col2 is presented.
  - Required: sp_data, sp_idx=5 and sp_w unchanged across the stall; total handshakes 13; col_rd_en count 6.
- Saturation (macro defined):
  - Stimulus: mean[0]=0x7F000000, col0[0]=0x02000000.
  - Required: idx1 element0 = 0x7FFFFFFF, sat_flag=1 from then to the end; idx2 element0 = 0x7D000000.
- Wrap (macro undefined):
  - Stimulus: same as the saturation case.
  - Required: idx1 element0 = 0x81000000, sat_flag=0.
- Reset mid-stream:
  - Stimulus: assert rstn=0 during EMIT_NEG of column 3.
  - Required: all outputs 0 asynchronously, no done pulse; a new start yields idx0 = the new mean.
- Start ignored while busy:
  - Stimulus: pulse start with a different mean during FETCH.
  - Required: the sequence continues with the original mean and the point count is unchanged.

Source files
------------

// File: rtl/ukf_sigma_seq_if.sv
// Sigma-point stream between ukf_sigma_seq (master) and the weighted-mean
// accumulator (slave): one N_STATE-element vector plus weight per handshake.
interface ukf_sigma_seq_if #(
    parameter int DATA_W  = 32,
    parameter int N_STATE = 6,
    parameter int IDX_W   = 4
);
    logic                        sp_valid;
    logic                        sp_ready;
    logic [N_STATE*DATA_W-1:0]   sp_data;
    logic [DATA_W-1:0]           sp_w;
    logic [IDX_W-1:0]            sp_idx;
    logic                        sp_last;

    modport master (
        output sp_valid, sp_data, sp_w, sp_idx, sp_last,
        input  sp_ready
    );

    modport slave (
        input  sp_valid, sp_data, sp_w, sp_idx, sp_last,
        output sp_ready
    );
endinterface

// File: rtl/ukf_sigma_seq.sv
// UKF sigma-point sequencer: emits mean, then mean +/- each covariance column.
// Define UKF_SIGMA_SAT_EN for saturating arithmetic and a sticky sat_flag.
module ukf_sigma_seq #(
    parameter int DATA_W    = 32,
    parameter int INT_BITS  = 8,
    parameter int FRAC_BITS = 24,
    parameter int N_STATE   = 6,
    parameter int COL_AW    = 3,
    parameter int IDX_W     = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [N_STATE*DATA_W-1:0] mean,
    input  logic [DATA_W-1:0]         w0,
    input  logic [DATA_W-1:0]         wi,
    output logic                      col_rd_en,
    output logic [COL_AW-1:0]         col_addr,
    input  logic [N_STATE*DATA_W-1:0] col_data,
    ukf_sigma_seq_if.master           sp,
    output logic                      busy,
    output logic                      done,
    output logic                      sat_flag
);

    localparam int VW = N_STATE * DATA_W;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_EMIT_MEAN = 3'd1;
    localparam logic [2:0] S_FETCH     = 3'd2;
    localparam logic [2:0] S_WAIT      = 3'd3;
    localparam logic [2:0] S_EMIT_POS  = 3'd4;
    localparam logic [2:0] S_EMIT_NEG  = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    localparam logic [COL_AW-1:0] LAST_COL = COL_AW'(N_STATE - 1);

    if (INT_BITS + FRAC_BITS != DATA_W) begin : g_fmt_err
        $error("ukf_sigma_seq: INT_BITS + FRAC_BITS must equal DATA_W");
    end

`ifdef UKF_SIGMA_SAT_EN
    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Returns {overflow, result}; the sum is formed one bit wider than the operands.
    function automatic logic [DATA_W:0] elem_op(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              sub);
        logic [DATA_W:0] s;
        s = sub ? ({a[DATA_W-1], a} - {b[DATA_W-1], b})
                : ({a[DATA_W-1], a} + {b[DATA_W-1], b});
        if (s[DATA_W] != s[DATA_W-1]) begin
            elem_op = {1'b1, (s[DATA_W] ? NEG_MIN : POS_MAX)};
        end else begin
            elem_op = {1'b0, s[DATA_W-1:0]};
        end
    endfunction
`else
    function automatic logic [DATA_W:0] elem_op(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              sub);
        elem_op = {1'b0, (sub ? (a - b) : (a + b))};
    endfunction
`endif

    logic [2:0]          state_q, state_d;
    logic [VW-1:0]       mean_q, mean_d;
    logic [VW-1:0]       col_q, col_d;
    logic [DATA_W-1:0]   wi_q, wi_d;
    logic [COL_AW-1:0]   c_q, c_d;
    logic [VW-1:0]       sp_data_q, sp_data_d;
    logic [DATA_W-1:0]   sp_w_q, sp_w_d;
    logic [IDX_W-1:0]    sp_idx_q, sp_idx_d;
    logic                sp_valid_q, sp_valid_d;
    logic                sp_last_q, sp_last_d;
    logic                col_rd_en_q, col_rd_en_d;
    logic [COL_AW-1:0]   col_addr_q, col_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sat_q, sat_d;

    logic [VW-1:0]       pos_data_s, neg_data_s;
    logic                pos_ov_s, neg_ov_s;
    logic [DATA_W:0]     pos_elem_s, neg_elem_s;
    logic                hs_s;

    // Element-wise mean+fresh column (for WAIT) and mean-captured column (for EMIT_POS).
    always_comb begin
        pos_data_s = '0;
        neg_data_s = '0;
        pos_ov_s   = 1'b0;
        neg_ov_s   = 1'b0;
        pos_elem_s = '0;
        neg_elem_s = '0;
        for (int j = 0; j < N_STATE; j++) begin
            pos_elem_s = elem_op(mean_q[j*DATA_W +: DATA_W], col_data[j*DATA_W +: DATA_W], 1'b0);
            neg_elem_s = elem_op(mean_q[j*DATA_W +: DATA_W], col_q[j*DATA_W +: DATA_W], 1'b1);
            pos_data_s[j*DATA_W +: DATA_W] = pos_elem_s[DATA_W-1:0];
            neg_data_s[j*DATA_W +: DATA_W] = neg_elem_s[DATA_W-1:0];
            pos_ov_s = pos_ov_s | pos_elem_s[DATA_W];
            neg_ov_s = neg_ov_s | neg_elem_s[DATA_W];
        end
    end

    assign hs_s = sp_valid_q & sp.sp_ready;

    // Sequencing FSM and point register updates.
    always_comb begin
        state_d   = state_q;
        mean_d    = mean_q;
        col_d     = col_q;
        wi_d      = wi_q;
        c_d       = c_q;
        sp_data_d = sp_data_q;
        sp_w_d    = sp_w_q;
        sp_idx_d  = sp_idx_q;
        sat_d     = sat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mean_d    = mean;
                    wi_d      = wi;
                    sat_d     = 1'b0;
                    sp_data_d = mean;
                    sp_w_d    = w0;
                    sp_idx_d  = '0;
                    state_d   = S_EMIT_MEAN;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_EMIT_MEAN: begin
                if (hs_s) begin
                    c_d     = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EMIT_MEAN;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                col_d     = col_data;
                sp_data_d = pos_data_s;
                sp_w_d    = wi_q;
                sp_idx_d  = IDX_W'({c_q, 1'b1});
                sat_d     = sat_q | pos_ov_s;
                state_d   = S_EMIT_POS;
            end
            S_EMIT_POS: begin
                if (hs_s) begin
                    sp_data_d = neg_data_s;
                    sp_idx_d  = IDX_W'({c_q, 1'b0}) + IDX_W'(2);
                    sat_d     = sat_q | neg_ov_s;
                    state_d   = S_EMIT_NEG;
                end else begin
                    state_d   = S_EMIT_POS;
                end
            end
            S_EMIT_NEG: begin
                if (hs_s && (c_q == LAST_COL)) begin
                    state_d = S_FINISH;
                end else if (hs_s) begin
                    c_d     = c_q + COL_AW'(1);
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EMIT_NEG;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they register alongside it.
    always_comb begin
        sp_valid_d  = (state_d == S_EMIT_MEAN) || (state_d == S_EMIT_POS) || (state_d == S_EMIT_NEG);
        sp_last_d   = (state_d == S_EMIT_NEG) && (c_d == LAST_COL);
        col_rd_en_d = (state_d == S_FETCH);
        col_addr_d  = (state_d == S_FETCH) ? c_d : '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FINISH);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            mean_q      <= '0;
            col_q       <= '0;
            wi_q        <= '0;
            c_q         <= '0;
            sp_data_q   <= '0;
            sp_w_q      <= '0;
            sp_idx_q    <= '0;
            sp_valid_q  <= 1'b0;
            sp_last_q   <= 1'b0;
            col_rd_en_q <= 1'b0;
            col_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mean_q      <= mean_d;
            col_q       <= col_d;
            wi_q        <= wi_d;
            c_q         <= c_d;
            sp_data_q   <= sp_data_d;
            sp_w_q      <= sp_w_d;
            sp_idx_q    <= sp_idx_d;
            sp_valid_q  <= sp_valid_d;
            sp_last_q   <= sp_last_d;
            col_rd_en_q <= col_rd_en_d;
            col_addr_q  <= col_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sat_q       <= sat_d;
        end
    end

    assign sp.sp_valid = sp_valid_q;
    assign sp.sp_data  = sp_data_q;
    assign sp.sp_w     = sp_w_q;
    assign sp.sp_idx   = sp_idx_q;
    assign sp.sp_last  = sp_last_q;
    assign col_rd_en   = col_rd_en_q;
    assign col_addr    = col_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sat_flag    = sat_q;

endmodule

// File: tb/tb_ukf_sigma_seq.sv
// Scoreboard bench for ukf_sigma_seq: a reference model queues the expected
// sigma points per start; a negedge monitor pops and compares on each handshake.
module tb_ukf_sigma_seq;

    localparam int DATA_W  = 32;
    localparam int N_STATE = 6;
    localparam int COL_AW  = 3;
    localparam int IDX_W   = 4;
    localparam int VW      = N_STATE * DATA_W;
    localparam int NPTS    = 2 * N_STATE + 1;

    logic                clk   = 1'b0;
    logic                rstn  = 1'b0;
    logic                start = 1'b0;
    logic [VW-1:0]       mean  = '0;
    logic [DATA_W-1:0]   w0    = '0;
    logic [DATA_W-1:0]   wi    = '0;
    logic                col_rd_en;
    logic [COL_AW-1:0]   col_addr;
    logic [VW-1:0]       col_data;
    logic                busy, done, sat_flag;

    ukf_sigma_seq_if #(.DATA_W(DATA_W), .N_STATE(N_STATE), .IDX_W(IDX_W)) sp_if ();

    ukf_sigma_seq #(
        .DATA_W(DATA_W), .INT_BITS(8), .FRAC_BITS(24),
        .N_STATE(N_STATE), .COL_AW(COL_AW), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .mean(mean), .w0(w0), .wi(wi),
        .col_rd_en(col_rd_en), .col_addr(col_addr), .col_data(col_data),
        .sp(sp_if), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0]     data;
        logic [DATA_W-1:0] w;
        logic [IDX_W-1:0]  idx;
        logic              last;
        logic              sat;
    } pt_t;

    pt_t               exp_q[$];
    logic [VW-1:0]     col_mem [N_STATE];
    logic [DATA_W-1:0] got_e0 [NPTS];
    int                total = 0;
    int                bad = 0;
    int                done_cnt = 0;
    int                hs_seq = 0;
    int                rd_seq = 0;
    int                ready_mode = 0;
    logic              ready_man = 1'b1;

`ifdef UKF_SIGMA_SAT_EN
    localparam longint MAXV = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DATA_W - 1));
`endif

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Reference model: mean, then mean +/- column c for each c, in plain integer arithmetic.
    task automatic push_seq(input logic [VW-1:0] m, input logic [DATA_W-1:0] a0,
                            input logic [DATA_W-1:0] ai);
        pt_t    p;
        bit     s_any;
        longint r;
        s_any  = 1'b0;
        p.data = m; p.w = a0; p.idx = '0; p.last = 1'b0; p.sat = 1'b0;
        exp_q.push_back(p);
        for (int c = 0; c < N_STATE; c++) begin
            for (int neg = 0; neg < 2; neg++) begin
                for (int j = 0; j < N_STATE; j++) begin
                    if (neg == 0)
                        r = longint'($signed(m[j*DATA_W +: DATA_W])) + longint'($signed(col_mem[c][j*DATA_W +: DATA_W]));
                    else
                        r = longint'($signed(m[j*DATA_W +: DATA_W])) - longint'($signed(col_mem[c][j*DATA_W +: DATA_W]));
`ifdef UKF_SIGMA_SAT_EN
                    if (r > MAXV) begin r = MAXV; s_any = 1'b1; end
                    else if (r < MINV) begin r = MINV; s_any = 1'b1; end
`endif
                    p.data[j*DATA_W +: DATA_W] = r[DATA_W-1:0];
                end
                p.w    = ai;
                p.idx  = IDX_W'(2 * c + 1 + neg);
                p.last = (c == N_STATE - 1) && (neg == 1);
                p.sat  = s_any;
                exp_q.push_back(p);
            end
        end
    endtask

    // Column RAM: data one cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (col_rd_en) col_data <= col_mem[col_addr];
        else           col_data <= {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    end

    // Consumer ready: tied high, random, or manual.
    always begin
        @(posedge clk);
        #2;
        if (ready_mode == 1)      sp_if.sp_ready = 1'($urandom_range(0, 1));
        else if (ready_mode == 0) sp_if.sp_ready = 1'b1;
        else                      sp_if.sp_ready = ready_man;
    end

    pt_t  mon_p, held_p;
    logic stall_prev = 1'b0;
    logic expect_done = 1'b0;

    // Monitor: handshake scoreboard, stall stability, done timing, column address order.
    always @(negedge clk) begin
        if (!rstn) begin
            stall_prev  = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (start && !busy) begin hs_seq = 0; rd_seq = 0; end
            if (expect_done) begin chk("done_after_last", done, 1); expect_done = 1'b0; end
            else if (done) chk("done_unexpected", done, 0);
            if (done) done_cnt++;
            if (col_rd_en) begin chk("col_addr", col_addr, rd_seq); rd_seq++; end
            if (stall_prev) begin
                chk("stall_valid", sp_if.sp_valid, 1);
                chk("stall_data", sp_if.sp_data, held_p.data);
                chk("stall_w", sp_if.sp_w, held_p.w);
                chk("stall_idx", sp_if.sp_idx, held_p.idx);
                chk("stall_last", sp_if.sp_last, held_p.last);
            end
            if (sp_if.sp_valid && sp_if.sp_ready) begin
                hs_seq++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_point: got idx=%0d want none", sp_if.sp_idx);
                end else begin
                    mon_p = exp_q.pop_front();
                    chk("pt_idx", sp_if.sp_idx, mon_p.idx);
                    chk("pt_data", sp_if.sp_data, mon_p.data);
                    chk("pt_w", sp_if.sp_w, mon_p.w);
                    chk("pt_last", sp_if.sp_last, mon_p.last);
                    chk("pt_sat", sat_flag, mon_p.sat);
                end
                if (int'(sp_if.sp_idx) < NPTS) got_e0[sp_if.sp_idx] = sp_if.sp_data[DATA_W-1:0];
                if (sp_if.sp_last) expect_done = 1'b1;
            end
            stall_prev  = sp_if.sp_valid && !sp_if.sp_ready;
            held_p.data = sp_if.sp_data;
            held_p.w    = sp_if.sp_w;
            held_p.idx  = sp_if.sp_idx;
            held_p.last = sp_if.sp_last;
        end
    end

    task automatic start_seq(input logic [VW-1:0] m, input logic [DATA_W-1:0] a0,
                             input logic [DATA_W-1:0] ai);
        @(posedge clk); #1;
        mean = m; w0 = a0; wi = ai;
        push_seq(m, a0, ai);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk("seq_done", done, 1);
        @(negedge clk);
        chk("points_per_seq", hs_seq, NPTS);
        chk("col_reads", rd_seq, N_STATE);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic rand_cols();
        for (int c = 0; c < N_STATE; c++)
            for (int j = 0; j < N_STATE; j++) col_mem[c][j*DATA_W +: DATA_W] = $urandom();
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int j = 0; j < N_STATE; j++) v[j*DATA_W +: DATA_W] = $urandom();
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, sp_if.sp_valid, 0);
        chk({tag, "_data"}, sp_if.sp_data, 0);
        chk({tag, "_w"}, sp_if.sp_w, 0);
        chk({tag, "_idx"}, sp_if.sp_idx, 0);
        chk({tag, "_last"}, sp_if.sp_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sat"}, sat_flag, 0);
        chk({tag, "_rd_en"}, col_rd_en, 0);
        chk({tag, "_addr"}, col_addr, 0);
    endtask

    initial begin
        int            k;
        int            d0;
        logic [VW-1:0] m, m2;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;

        // Basic: mean 1.0, columns 0.5, ready tied high
        ready_mode = 0;
        for (int c = 0; c < N_STATE; c++) col_mem[c] = {N_STATE{32'h0080_0000}};
        start_seq({N_STATE{32'h0100_0000}}, 32'h0055_5555, 32'h0015_5555);
        wait_done(k);
        chk("min_seq_len", k, 2 + 4 * N_STATE);
        chk("basic_idx0", got_e0[0], 32'h0100_0000);
        chk("basic_idx1", got_e0[1], 32'h0180_0000);
        chk("basic_idx2", got_e0[2], 32'h0080_0000);
        chk("basic_idx11", got_e0[11], 32'h0180_0000);
        chk("basic_idx12", got_e0[12], 32'h0080_0000);

        // Backpressure: 3 stall cycles on +col2 (idx 5)
        ready_mode = 2; ready_man = 1'b1;
        rand_cols();
        start_seq(rand_vec(), $urandom(), $urandom());
        k = 0;
        while (!(col_rd_en === 1'b1 && col_addr == COL_AW'(2)) && k < 200) begin @(negedge clk); k++; end
        chk("stall_fetch_seen", k < 200, 1);
        ready_man = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp_idx", sp_if.sp_idx, 5);
            chk("bp_valid", sp_if.sp_valid, 1);
        end
        ready_man = 1'b1;
        wait_done(k);

        // Overflow on element 0 of +col0
        ready_mode = 1;
        for (int c = 0; c < N_STATE; c++) col_mem[c] = {N_STATE{32'h0010_0000}};
        col_mem[0][DATA_W-1:0] = 32'h0200_0000;
        m = '0;
        m[DATA_W-1:0] = 32'h7F00_0000;
        start_seq(m, 32'h0000_1000, 32'h0000_2000);
        wait_done(k);
`ifdef UKF_SIGMA_SAT_EN
        chk("ovf_idx1", got_e0[1], 32'h7FFF_FFFF);
        chk("ovf_sat_end", sat_flag, 1);
`else
        chk("ovf_idx1", got_e0[1], 32'h8100_0000);
        chk("ovf_sat_end", sat_flag, 0);
`endif
        chk("ovf_idx2", got_e0[2], 32'h7D00_0000);

        // Randomized sequences with random backpressure
        for (int t = 0; t < 3; t++) begin
            rand_cols();
            start_seq(rand_vec(), $urandom(), $urandom());
            wait_done(k);
        end

        // Start pulsed during FETCH is ignored
        ready_mode = 0;
        rand_cols();
        m = rand_vec();
        start_seq(m, $urandom(), $urandom());
        k = 0;
        while (col_rd_en !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("ign_fetch_seen", k < 200, 1);
        mean  = ~m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(k);

        // Reset during EMIT_NEG of column 3
        rand_cols();
        start_seq(rand_vec(), $urandom(), $urandom());
        k = 0;
        while (!(sp_if.sp_valid === 1'b1 && sp_if.sp_idx == IDX_W'(8)) && k < 200) begin @(negedge clk); k++; end
        chk("rst_neg3_seen", k < 200, 1);
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle", busy, 0);
        m2 = rand_vec();
        start_seq(m2, $urandom(), $urandom());
        wait_done(k);
        chk("midrst_new_idx0", got_e0[0], m2[DATA_W-1:0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
